// File: rtl/ddr3_cmd_resp.sv
// DDR3 config/refresh command responder: issues MRS/ZQCL/PRE/NOP/REF on the
// pseudo-DFI pins and pulses cfg_rdy_o after the timing wait. Option: DDR3_CMD_CHECK_EN.
module ddr3_cmd_resp #(
  parameter int DDR_ROW_BITS = 13,
  parameter int DDR_CMOD     = 12,
  parameter int DDR_CZQINIT  = 512,
  parameter int DDR_CRP      = 2,
  parameter int DDR_CRFC     = 11
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cfg_req_i,
  input  logic                    cfg_run_i,
  input  logic [2:0]              cfg_cmd_i,
  input  logic                    cfg_ref_i,
  input  logic [2:0]              cfg_ba_i,
  input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
  output logic                    cfg_rdy_o,
  input  logic                    ctl_idle_i,
  output logic                    ref_busy_o,
  output logic                    err_o,
  output logic                    dfi_ras_no,
  output logic                    dfi_cas_no,
  output logic                    dfi_we_no,
  output logic [2:0]              dfi_bank_o,
  output logic [DDR_ROW_BITS-1:0] dfi_addr_o
);

  localparam int MAXA = (DDR_CMOD > DDR_CZQINIT) ? DDR_CMOD : DDR_CZQINIT;
  localparam int MAXB = (DDR_CRP > DDR_CRFC) ? DDR_CRP : DDR_CRFC;
  localparam int MAXC = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int MAXW = (MAXC > 1) ? MAXC : 1;
  localparam int CW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] W_MOD = CW'(DDR_CMOD);
  localparam logic [CW-1:0] W_ZQ  = CW'(DDR_CZQINIT);
  localparam logic [CW-1:0] W_RP  = CW'(DDR_CRP);
  localparam logic [CW-1:0] W_RFC = CW'(DDR_CRFC);
  localparam logic [CW-1:0] W_ONE = CW'(1);
  localparam logic [CW-1:0] W_TWO = CW'(2);

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ZQ  = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [2:0]              cmd_q;
  logic [2:0]              bank_q;
  logic [DDR_ROW_BITS-1:0] addr_q;
  logic                    rdy_q;
  logic                    busy_q;
  logic [CW-1:0]           req_wait;

`ifdef DDR3_CMD_CHECK_EN
  logic                    illegal;
  logic                    err_q;
`endif

  // Wait value for a sequencer command; anything outside the table waits one cycle
  always_comb begin
    req_wait = W_ONE;
`ifdef DDR3_CMD_CHECK_EN
    illegal  = 1'b0;
`endif
    unique case (cfg_cmd_i)
      C_MRS:   req_wait = W_MOD;
      C_PRE:   req_wait = W_RP;
      C_ZQ:    req_wait = W_ZQ;
      C_NOP:   req_wait = W_ONE;
      default: begin
        req_wait = W_ONE;
`ifdef DDR3_CMD_CHECK_EN
        illegal  = 1'b1;
`endif
      end
    endcase
  end

  // Command FSM: DONE registers the completion pulse, which is visible during HOLD
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= C_NOP;
      bank_q  <= '0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DDR3_CMD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!cfg_run_i && cfg_req_i) begin
            state_q <= S_ISSUE;
            cnt_q   <= req_wait;
`ifdef DDR3_CMD_CHECK_EN
            if (illegal) begin
              err_q  <= 1'b1;
              cmd_q  <= C_NOP;
              bank_q <= '0;
              addr_q <= '0;
            end else begin
              cmd_q  <= cfg_cmd_i;
              bank_q <= cfg_ba_i;
              addr_q <= cfg_adr_i;
            end
`else
            cmd_q  <= cfg_cmd_i;
            bank_q <= cfg_ba_i;
            addr_q <= cfg_adr_i;
`endif
          end else if (cfg_run_i && cfg_ref_i && ctl_idle_i) begin
            state_q <= S_ISSUE;
            cnt_q   <= W_RFC;
            cmd_q   <= C_REF;
            bank_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          cmd_q  <= C_NOP;
          bank_q <= '0;
          addr_q <= '0;
          cnt_q  <= cnt_q - W_ONE;
          if (cnt_q <= W_ONE) begin
            rdy_q   <= 1'b1;
            state_q <= S_HOLD;
          end else if (cnt_q == W_TWO) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - W_ONE;
          if (cnt_q <= W_TWO) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          rdy_q   <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign {dfi_ras_no, dfi_cas_no, dfi_we_no} = cmd_q;
  assign dfi_bank_o = bank_q;
  assign dfi_addr_o = addr_q;
  assign cfg_rdy_o  = rdy_q;
  assign ref_busy_o = busy_q;

`ifdef DDR3_CMD_CHECK_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_cmd_resp.sv
// Randomised + directed bench for ddr3_cmd_resp against a schedule-level
// model: each accepted request fixes its pin cycle, rdy cycle and next-free cycle.
module tb_ddr3_cmd_resp;

  localparam int RB    = 13;
  localparam int TMOD  = 12;
  localparam int TZQ   = 512;
  localparam int TRP   = 2;
  localparam int TRFC  = 11;

`ifdef DDR3_CMD_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0;
  logic          run = 1'b0;
  logic [2:0]    cmd = 3'b111;
  logic          rf = 1'b0;
  logic [2:0]    ba = '0;
  logic [RB-1:0] adr = '0;
  logic          idle = 1'b0;
  logic          rdy, busy, err, ras_n, cas_n, we_n;
  logic [2:0]    bank;
  logic [RB-1:0] addr;

  ddr3_cmd_resp #(
    .DDR_ROW_BITS(RB), .DDR_CMOD(TMOD), .DDR_CZQINIT(TZQ),
    .DDR_CRP(TRP), .DDR_CRFC(TRFC)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_req_i(req), .cfg_run_i(run), .cfg_cmd_i(cmd),
    .cfg_ref_i(rf), .cfg_ba_i(ba), .cfg_adr_i(adr),
    .cfg_rdy_o(rdy), .ctl_idle_i(idle), .ref_busy_o(busy),
    .err_o(err), .dfi_ras_no(ras_n), .dfi_cas_no(cas_n),
    .dfi_we_no(we_n), .dfi_bank_o(bank), .dfi_addr_o(addr)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // model schedule
  int free_at = 0;
  int iss_t = -100;
  int rdy_t = -100;
  int bs = -100;
  int be = -200;
  logic [2:0]    m_cmd = 3'b111;
  logic [2:0]    m_ba = '0;
  logic [RB-1:0] m_adr = '0;
  bit m_err = 1'b0;
  bit acc_now = 1'b0;
  bit rdy_now = 1'b0;

  int rdy_log[$];
  int ref_log[$];
  int busy_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int wait_of(input logic [2:0] c);
    case (c)
      3'b000:  return TMOD;
      3'b010:  return TRP;
      3'b110:  return TZQ;
      default: return 1;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b010) || (c == 3'b110) || (c == 3'b111);
  endfunction

  task automatic tick();
    int n;
    logic [2:0] exp_cmd;
    logic [2:0] exp_ba;
    logic [RB-1:0] exp_adr;
    @(posedge clock);
    cyc++;
    acc_now = 1'b0;
    if (!reset_n) begin
      free_at = 0;
      iss_t = -100;
      rdy_t = -100;
      bs = -100;
      be = -200;
      m_err = 1'b0;
    end else if (cyc >= free_at) begin
      if (!run && req) begin
        n = wait_of(cmd);
        acc_now = 1'b1;
        iss_t = cyc;
        rdy_t = cyc + n;
        free_at = cyc + n + 2;
        if (CHK_EN && !legal(cmd)) begin
          m_err = 1'b1;
          m_cmd = 3'b111;
          m_ba = '0;
          m_adr = '0;
        end else begin
          m_cmd = cmd;
          m_ba = ba;
          m_adr = adr;
        end
      end else if (run && rf && idle) begin
        acc_now = 1'b1;
        iss_t = cyc;
        rdy_t = cyc + TRFC;
        free_at = cyc + TRFC + 2;
        bs = cyc;
        be = cyc + TRFC;
        m_cmd = 3'b001;
        m_ba = '0;
        m_adr = '0;
      end
    end
    #1;
    rdy_now = reset_n && (cyc == rdy_t);
    if (reset_n && cyc == iss_t) begin
      exp_cmd = m_cmd;
      exp_ba = m_ba;
      exp_adr = m_adr;
    end else begin
      exp_cmd = 3'b111;
      exp_ba = '0;
      exp_adr = '0;
    end
    chk("pins", {ras_n, cas_n, we_n}, exp_cmd);
    chk("bank", bank, exp_ba);
    chk("addr", addr, exp_adr);
    chk("rdy", rdy, rdy_now);
    chk("busy", busy, reset_n && cyc >= bs && cyc <= be);
    chk("err", err, m_err);
    if (rdy) rdy_log.push_back(cyc);
    if ({ras_n, cas_n, we_n} == 3'b001) ref_log.push_back(cyc);
    if (busy) busy_cnt++;
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [2:0] b,
                        input logic [RB-1:0] a, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    cmd = c;
    ba = b;
    adr = a;
    req = 1'b1;
    for (int k = 0; k < 2000 && !done; k++) begin
      tick();
      if (acc_now && acc < 0) acc = cyc;
      if (rdy_now) done = 1'b1;
    end
    req = 1'b0;
    chk("cmd_done", done, 1);
  endtask

  int e0;
  int dummy;
  int offs[6] = '{12, 26, 40, 54, 568, 572};
  int nr;

  initial begin
    // reset, then 20 idle cycles
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // init sequence
    rdy_log.delete();
    do_cmd(3'b000, 3'd2, 13'h0000, e0);
    do_cmd(3'b000, 3'd3, 13'h0000, dummy);
    do_cmd(3'b000, 3'd1, 13'h0044, dummy);
    do_cmd(3'b000, 3'd0, 13'h0520, dummy);
    do_cmd(3'b110, 3'd0, 13'h0400, dummy);
    do_cmd(3'b010, 3'd0, 13'h0400, dummy);
    for (int i = 0; i < 5; i++) tick();
    chk("init_pulses", rdy_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rdy_log.size()) chk("init_off", rdy_log[i] - e0, offs[i]);

    // refresh blocked by busy controller, MRS request ignored during run
    run = 1'b1;
    rf = 1'b1;
    idle = 1'b0;
    req = 1'b1;
    cmd = 3'b000;
    ref_log.delete();
    rdy_log.delete();
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) tick();
    chk("ref_blocked", ref_log.size(), 0);
    idle = 1'b1;
    nr = 0;
    for (int k = 0; k < 200 && nr < 2; k++) begin
      tick();
      if (rdy_now) nr++;
    end
    rf = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("ref_count", ref_log.size(), 2);
    if (ref_log.size() >= 2) chk("ref_space", ref_log[1] - ref_log[0], 13);
    chk("ref_rdy", rdy_log.size(), 2);
    chk("ref_busy", busy_cnt, 24);

    // illegal commands
    run = 1'b0;
    rdy_log.delete();
    do_cmd(3'b101, 3'd5, 13'h1abc, e0);
    do_cmd(3'b001, 3'd1, 13'h0001, dummy);
    for (int i = 0; i < 4; i++) tick();
    if (rdy_log.size() > 0) chk("illegal_lat", rdy_log[0] - e0, 1);
    chk("err_sticky", err, CHK_EN);

    // reset pulse mid-ZQCL
    cmd = 3'b110;
    req = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    req = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) run = ~run;
      req = ($urandom_range(0, 3) != 0);
      cmd = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && cmd == 3'b110) cmd = 3'b000;
      ba = 3'($urandom_range(0, 7));
      adr = RB'($urandom);
      rf = $urandom_range(0, 1);
      idle = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
